dwt_haar_mac: RTL and testbench
===============================

Name: dwt_haar_mac

Overview:
- Arithmetic stage directly downstream of the DWT control/memory sequencer.
- Consumes each 16-bit pixel pair plus its mode and pointer tags, and computes the Haar low/high coefficients (L, H).
- Returns the coefficient pair to the sequencer with the original tags echoed, so the sequencer can form write addresses.
- Tracks row-pass / column-pass progress, flags out-of-order input, and signals pass and level completion.

Parameters:
- WIDTH, 256: image width in pixels; even, ≥4.
- HEIGHT, 256: image height in pixels; even, ≥4.
- MAX_LEVEL, 1: number of decomposition levels; final level raises o_all_done.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous active-low reset.
- i_pair  input  16  pixel pair; [15:8] = a (even pixel), [7:0] = b (odd pixel).
- i_valid  input  1  pair and tags valid this cycle.
- i_mode  input  1  0 = row pass, 1 = column pass.
- i_row_column_pointer  input  $clog2(WIDTH)  row index (mode 0) or column index (mode 1).
- i_pixel_pointer  input  $clog2(WIDTH)  even pixel index within the row/column.
- o_coef  output  16  {L,H}; [15:8] = L, [7:0] = H.
- o_valid  output  1  o_coef and tags valid.
- o_mode  output  1  echoed i_mode.
- o_row_column_pointer  output  $clog2(WIDTH)  echoed pointer.
- o_pixel_pointer  output  $clog2(WIDTH)  echoed pointer.
- o_pass_done  output  1  one-cycle pulse with the last coefficient of a pass.
- o_level  output  3  completed decomposition levels.
- o_all_done  output  1  sticky; set when o_level reaches MAX_LEVEL.
- o_seq_err  output  1  sticky; set on a tag sequence mismatch.

Behaviour:
- Reset (rst low, async): all outputs 0, FSM = IDLE, expected pointers 0, pipeline valids 0.
- Pipeline: 2 stages, latency exactly 2 cycles, throughput 1 pair/cycle, no backpressure.
- o_valid(n+2) = i_valid(n). Tags travel with data through both stages.
- Stage 1 registers:
  - s = a + b, 9-bit unsigned.
  - d = a − b, 9-bit signed.
- Stage 2 registers:
  - L = s >> 1.
  - H = (d >>> 1) + 128, result range 0..255.
- o_coef holds its last value when o_valid = 0.
- FSM states: IDLE, ROW, COL. Expected pointers exp_rc / exp_px, checked on every i_valid.
  - IDLE: on i_valid → ROW, and that pair is checked against mode 0, rc 0, px 0.
  - ROW: expects mode 0. After each pair, exp_px += 2; at WIDTH−2, exp_px wraps to 0 and exp_rc += 1.
    - Pair (px = WIDTH−2, rc = HEIGHT−1) is the last of the pass: → COL, expected pointers cleared.
  - COL: same scheme with px limit HEIGHT−2 and rc limit WIDTH−1.
    - Last pair: → IDLE, and o_level increments when that pair exits stage 2.
- Mismatch (mode, rc or px ≠ expected):
  - o_seq_err set.
  - Data is still computed and output.
  - Expected pointers resync to the received tags, then advance.
  - Pass-end detection uses the received tags.
- o_pass_done pulses in the same cycle as o_valid for a pass's last pair.
- o_all_done sets in the cycle o_level becomes MAX_LEVEL.
  - While o_all_done is set, further i_valid is still processed, but o_level saturates and o_seq_err is set.
- i_valid while i_mode changes mid-pass counts as a mismatch.
- Reset asserted mid-pass: pipeline contents discarded, no o_valid or o_pass_done emitted after release until new input arrives.

Optional Feature:
- DWT_ROUND_EN defined:
  - L = (s + 1) >> 1.
  - H = ((d + 1) >>> 1) + 128, saturated to 255.
- DWT_ROUND_EN undefined: truncating arithmetic as specified in Behaviour; no saturation logic.
- Latency is 2 cycles in both builds.

Test Plan:
- Arithmetic, a=200, b=100 → 2 cycles later o_coef = {150, 178}, tags echoed unchanged.
- Extremes, a=0, b=255 → H = 0 (H = 1 with DWT_ROUND_EN).
- Extremes, a=255, b=0 → L = 127, H = 255 (L = 128, H = 255 saturated with DWT_ROUND_EN).
- Pass sequencing, WIDTH=HEIGHT=4, MAX_LEVEL=1, 8 back-to-back row pairs then 8 column pairs, correct tags:
  - o_pass_done pulses twice, with the 8th and 16th o_valid.
  - o_level = 1, o_all_done = 1, o_seq_err = 0.
- Out-of-order, send row pair px=2 where px=0 expected → o_seq_err = 1 and stays set; the following correctly advancing pairs still complete the pass.
- Reset mid-pass, drop rst for 1 cycle after 3 pairs:
  - All outputs 0 immediately (async).
  - No o_valid after release.
  - The next pair at (0,0) is accepted without error.

Source files
------------

// File: rtl/dwt_haar_mac.sv
// Haar DWT arithmetic stage: 2-cycle pipelined {L,H} pair computation with row/column pass tracking.
// Optional build macro DWT_ROUND_EN selects rounding arithmetic with H saturation instead of truncation.
module dwt_haar_mac #(
    parameter int WIDTH     = 256,
    parameter int HEIGHT    = 256,
    parameter int MAX_LEVEL = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [15:0]                i_pair,
    input  logic                       i_valid,
    input  logic                       i_mode,
    input  logic [$clog2(WIDTH)-1:0]   i_row_column_pointer,
    input  logic [$clog2(WIDTH)-1:0]   i_pixel_pointer,
    output logic [15:0]                o_coef,
    output logic                       o_valid,
    output logic                       o_mode,
    output logic [$clog2(WIDTH)-1:0]   o_row_column_pointer,
    output logic [$clog2(WIDTH)-1:0]   o_pixel_pointer,
    output logic                       o_pass_done,
    output logic [2:0]                 o_level,
    output logic                       o_all_done,
    output logic                       o_seq_err
);

    localparam int PW = $clog2(WIDTH);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ROW  = 2'd1;
    localparam logic [1:0] ST_COL  = 2'd2;

    localparam logic [PW-1:0] ROW_PX_LAST = PW'(WIDTH - 2);
    localparam logic [PW-1:0] ROW_RC_LAST = PW'(HEIGHT - 1);
    localparam logic [PW-1:0] COL_PX_LAST = PW'(HEIGHT - 2);
    localparam logic [PW-1:0] COL_RC_LAST = PW'(WIDTH - 1);
    localparam logic [2:0]    LEVEL_MAX   = 3'(MAX_LEVEL);

    logic [1:0]    state_q, state_d;
    logic [PW-1:0] exp_rc_q, exp_rc_d;
    logic [PW-1:0] exp_px_q, exp_px_d;
    logic          exp_mode_s;
    logic          mismatch_s;
    logic          pass_last_s;
    logic [PW-1:0] px_last_s;
    logic [PW-1:0] rc_last_s;

    logic [8:0]    s_s;
    logic [8:0]    d_s;

    logic                 s1_valid_q;
    logic [8:0]           s1_s_q;
    logic signed [8:0]    s1_d_q;
    logic                 s1_mode_q;
    logic [PW-1:0]        s1_rc_q;
    logic [PW-1:0]        s1_px_q;
    logic                 s1_last_q;
    logic                 s1_lvl_q;

    logic [7:0]    l_s;
    logic [7:0]    h_s;

    logic [15:0]   o_coef_q;
    logic          o_valid_q;
    logic          o_mode_q;
    logic [PW-1:0] o_rc_q;
    logic [PW-1:0] o_px_q;
    logic          o_pass_done_q;
    logic [2:0]    o_level_q, o_level_d;
    logic          o_all_done_q, o_all_done_d;
    logic          o_seq_err_q, o_seq_err_d;

    // Sequence tracking: check incoming tags, resync to them, and advance from the received position.
    always_comb begin
        state_d  = state_q;
        exp_rc_d = exp_rc_q;
        exp_px_d = exp_px_q;
        case (state_q)
            ST_ROW:  exp_mode_s = 1'b0;
            ST_COL:  exp_mode_s = 1'b1;
            default: exp_mode_s = 1'b0;
        endcase
        mismatch_s  = (i_mode != exp_mode_s) ||
                      (i_row_column_pointer != exp_rc_q) ||
                      (i_pixel_pointer != exp_px_q);
        px_last_s   = i_mode ? COL_PX_LAST : ROW_PX_LAST;
        rc_last_s   = i_mode ? COL_RC_LAST : ROW_RC_LAST;
        pass_last_s = (i_pixel_pointer == px_last_s) && (i_row_column_pointer == rc_last_s);
        if (i_valid) begin
            if (pass_last_s) begin
                exp_rc_d = {PW{1'b0}};
                exp_px_d = {PW{1'b0}};
                state_d  = i_mode ? ST_IDLE : ST_COL;
            end else if (i_pixel_pointer == px_last_s) begin
                exp_px_d = {PW{1'b0}};
                exp_rc_d = i_row_column_pointer + PW'(1);
                state_d  = i_mode ? ST_COL : ST_ROW;
            end else begin
                exp_px_d = i_pixel_pointer + PW'(2);
                exp_rc_d = i_row_column_pointer;
                state_d  = i_mode ? ST_COL : ST_ROW;
            end
        end else begin
            state_d = state_q;
        end
        o_seq_err_d = o_seq_err_q | (i_valid & (mismatch_s | o_all_done_q));
    end

    // Stage 1 arithmetic: 9-bit sum and 9-bit two's complement difference.
    always_comb begin
        s_s = {1'b0, i_pair[15:8]} + {1'b0, i_pair[7:0]};
        d_s = {1'b0, i_pair[15:8]} - {1'b0, i_pair[7:0]};
    end

`ifdef DWT_ROUND_EN
    logic [9:0]        s_rnd_s;
    logic signed [9:0] d_ext_s;
    logic signed [9:0] d_rnd_s;
    logic signed [9:0] h_sum_s;

    // Stage 2 rounding arithmetic; H can only reach 256 on the positive side, so clamp that.
    always_comb begin
        s_rnd_s = {1'b0, s1_s_q} + 10'd1;
        l_s     = 8'(s_rnd_s >> 1);
        d_ext_s = {s1_d_q[8], s1_d_q};
        d_rnd_s = d_ext_s + 10'sd1;
        h_sum_s = (d_rnd_s >>> 1) + 10'sd128;
        if (h_sum_s[8]) begin
            h_s = 8'hFF;
        end else begin
            h_s = 8'(h_sum_s);
        end
    end
`else
    logic signed [8:0] d_sh_s;
    logic signed [8:0] h_sum_s;

    // Stage 2 truncating arithmetic; the +128 bias maps H into 0..255 without overflow.
    always_comb begin
        l_s     = 8'(s1_s_q >> 1);
        d_sh_s  = s1_d_q >>> 1;
        h_sum_s = d_sh_s + 9'sd128;
        h_s     = 8'(h_sum_s);
    end
`endif

    // Level counter saturates; all_done follows it in the same cycle.
    always_comb begin
        if (s1_valid_q && s1_lvl_q && (o_level_q < LEVEL_MAX)) begin
            o_level_d = o_level_q + 3'd1;
        end else begin
            o_level_d = o_level_q;
        end
        o_all_done_d = o_all_done_q | (o_level_d == LEVEL_MAX);
    end

    // Sequencer state and expected pointers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            exp_rc_q <= {PW{1'b0}};
            exp_px_q <= {PW{1'b0}};
        end else begin
            state_q  <= state_d;
            exp_rc_q <= exp_rc_d;
            exp_px_q <= exp_px_d;
        end
    end

    // Stage 1 pipeline register; the pass-end and level flags ride along with the data.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid_q <= 1'b0;
            s1_s_q     <= 9'd0;
            s1_d_q     <= 9'sd0;
            s1_mode_q  <= 1'b0;
            s1_rc_q    <= {PW{1'b0}};
            s1_px_q    <= {PW{1'b0}};
            s1_last_q  <= 1'b0;
            s1_lvl_q   <= 1'b0;
        end else begin
            s1_valid_q <= i_valid;
            if (i_valid) begin
                s1_s_q    <= s_s;
                s1_d_q    <= d_s;
                s1_mode_q <= i_mode;
                s1_rc_q   <= i_row_column_pointer;
                s1_px_q   <= i_pixel_pointer;
                s1_last_q <= pass_last_s;
                s1_lvl_q  <= i_mode & pass_last_s;
            end
        end
    end

    // Stage 2 output register; coefficient and tags hold while no pair is exiting.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            o_coef_q      <= 16'd0;
            o_valid_q     <= 1'b0;
            o_mode_q      <= 1'b0;
            o_rc_q        <= {PW{1'b0}};
            o_px_q        <= {PW{1'b0}};
            o_pass_done_q <= 1'b0;
            o_level_q     <= 3'd0;
            o_all_done_q  <= 1'b0;
            o_seq_err_q   <= 1'b0;
        end else begin
            o_valid_q     <= s1_valid_q;
            o_pass_done_q <= s1_valid_q & s1_last_q;
            o_level_q     <= o_level_d;
            o_all_done_q  <= o_all_done_d;
            o_seq_err_q   <= o_seq_err_d;
            if (s1_valid_q) begin
                o_coef_q <= {l_s, h_s};
                o_mode_q <= s1_mode_q;
                o_rc_q   <= s1_rc_q;
                o_px_q   <= s1_px_q;
            end
        end
    end

    assign o_coef               = o_coef_q;
    assign o_valid              = o_valid_q;
    assign o_mode               = o_mode_q;
    assign o_row_column_pointer = o_rc_q;
    assign o_pixel_pointer      = o_px_q;
    assign o_pass_done          = o_pass_done_q;
    assign o_level              = o_level_q;
    assign o_all_done           = o_all_done_q;
    assign o_seq_err            = o_seq_err_q;

endmodule

// File: tb/tb_dwt_haar_mac.sv
// Randomized self-checking bench for dwt_haar_mac (4x4 image, one level) against a behavioural model.
module tb_dwt_haar_mac;

    localparam int W    = 4;
    localparam int H    = 4;
    localparam int MAXL = 1;
    localparam int PASS = (W / 2) * H;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] i_pair = 16'd0;
    logic        i_valid = 1'b0;
    logic        i_mode = 1'b0;
    logic [1:0]  i_rc = 2'd0;
    logic [1:0]  i_px = 2'd0;
    logic [15:0] o_coef;
    logic        o_valid;
    logic        o_mode;
    logic [1:0]  o_rc;
    logic [1:0]  o_px;
    logic        o_pass_done;
    logic [2:0]  o_level;
    logic        o_all_done;
    logic        o_seq_err;

    dwt_haar_mac #(.WIDTH(W), .HEIGHT(H), .MAX_LEVEL(MAXL)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .i_pair               (i_pair),
        .i_valid              (i_valid),
        .i_mode               (i_mode),
        .i_row_column_pointer (i_rc),
        .i_pixel_pointer      (i_px),
        .o_coef               (o_coef),
        .o_valid              (o_valid),
        .o_mode               (o_mode),
        .o_row_column_pointer (o_rc),
        .o_pixel_pointer      (o_px),
        .o_pass_done          (o_pass_done),
        .o_level              (o_level),
        .o_all_done           (o_all_done),
        .o_seq_err            (o_seq_err)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_miss = 0;

    // model state
    int          m_idx = 0;
    bit          m_err = 1'b0;
    int          m_level = 0;
    bit          m_all_done = 1'b0;
    bit          prev_v = 1'b0;
    bit          prev_pd = 1'b0;
    bit          prev_lvl = 1'b0;
    logic [20:0] prev_out = 21'd0;
    logic [15:0] last_coef = 16'd0;

    int          n_out = 0;
    int          pd_cnt = 0;
    int          pd_hist [4];
    logic [15:0] first_coef [3];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int floor_half(input int x);
        return (x >= 0) ? x / 2 : -((1 - x) / 2);
    endfunction

    function automatic int ref_l(input int a, input int b);
`ifdef DWT_ROUND_EN
        return (a + b + 1) / 2;
`else
        return (a + b) / 2;
`endif
    endfunction

    function automatic int ref_h(input int a, input int b);
        int h;
`ifdef DWT_ROUND_EN
        h = floor_half(a - b + 1) + 128;
        if (h > 255) h = 255;
`else
        h = floor_half(a - b) + 128;
`endif
        return h;
    endfunction

    task automatic clear_stats();
        n_out  = 0;
        pd_cnt = 0;
    endtask

    // One clock: drive inputs, advance, then check the outputs of the pair issued one step earlier.
    task automatic step(input bit v, input int a, input int b, input int m, input int rc, input int px);
        bit          c_pd;
        bit          c_lvl;
        logic [20:0] c_out;
        int          rx;
        int          lv;
        int          hv;
        i_valid = v;
        i_pair  = {a[7:0], b[7:0]};
        i_mode  = m[0];
        i_rc    = rc[1:0];
        i_px    = px[1:0];
        c_pd    = 1'b0;
        c_lvl   = 1'b0;
        c_out   = 21'd0;
        if (v) begin
            rx = m * PASS + rc * (W / 2) + px / 2;
            if (rx != m_idx || m_all_done) m_err = 1'b1;
            c_pd  = (rx % PASS) == PASS - 1;
            c_lvl = c_pd && (m == 1);
            m_idx = (rx + 1) % (2 * PASS);
            lv    = ref_l(a, b);
            hv    = ref_h(a, b);
            c_out = {lv[7:0], hv[7:0], m[0], rc[1:0], px[1:0]};
        end
        @(posedge clk);
        #1;
        if (o_valid) begin
            n_out++;
            if (n_out <= 3) first_coef[n_out-1] = o_coef;
            if (o_pass_done && pd_cnt < 4) begin
                pd_hist[pd_cnt] = n_out;
                pd_cnt++;
            end
        end
        check("valid", {31'd0, o_valid}, {31'd0, prev_v});
        if (prev_v) begin
            check("data", {11'd0, o_coef, o_mode, o_rc, o_px}, {11'd0, prev_out});
            last_coef = prev_out[20:5];
            if (prev_lvl && m_level < MAXL) m_level++;
            if (m_level == MAXL) m_all_done = 1'b1;
        end else begin
            check("hold", {16'd0, o_coef}, {16'd0, last_coef});
        end
        check("pass_done", {31'd0, o_pass_done}, {31'd0, prev_v & prev_pd});
        check("level", {29'd0, o_level}, m_level);
        check("all_done", {31'd0, o_all_done}, {31'd0, m_all_done});
        prev_v   = v;
        prev_pd  = c_pd;
        prev_lvl = c_lvl;
        prev_out = c_out;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        rst     = 1'b0;
        i_valid = 1'b0;
        #1;
        check("reset_outs", {4'd0, o_coef, o_valid, o_mode, o_rc, o_px, o_pass_done, o_level, o_all_done, o_seq_err}, 32'd0);
        m_idx      = 0;
        m_err      = 1'b0;
        m_level    = 0;
        m_all_done = 1'b0;
        prev_v     = 1'b0;
        prev_pd    = 1'b0;
        prev_lvl   = 1'b0;
        prev_out   = 21'd0;
        last_coef  = 16'd0;
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        int a;
        int b;
        int m;
        int rc;
        int px;
        #2;
        do_reset();

        // full level with correct tags; first three pairs are the arithmetic corner cases
        clear_stats();
        for (int k = 0; k < 2 * PASS; k++) begin
            m  = k / PASS;
            rc = (k % PASS) / (W / 2);
            px = (k % (W / 2)) * 2;
            if (k == 0)      begin a = 200; b = 100; end
            else if (k == 1) begin a = 0;   b = 255; end
            else if (k == 2) begin a = 255; b = 0;   end
            else begin a = int'($urandom_range(255)); b = int'($urandom_range(255)); end
            step(1'b1, a, b, m, rc, px);
        end
        idle(3);
        check("coef_200_100", {16'd0, first_coef[0]}, {16'd0, 8'd150, 8'd178});
`ifdef DWT_ROUND_EN
        check("coef_0_255", {16'd0, first_coef[1]}, {16'd0, 8'd128, 8'd1});
        check("coef_255_0", {16'd0, first_coef[2]}, {16'd0, 8'd128, 8'd255});
`else
        check("coef_0_255", {16'd0, first_coef[1]}, {16'd0, 8'd127, 8'd0});
        check("coef_255_0", {16'd0, first_coef[2]}, {16'd0, 8'd127, 8'd255});
`endif
        check("pd_count", pd_cnt, 2);
        check("pd_first_at", pd_hist[0], 8);
        check("pd_second_at", pd_hist[1], 16);
        check("level_final", {29'd0, o_level}, 1);
        check("all_done_final", {31'd0, o_all_done}, 1);
        check("seq_err_clean", {31'd0, o_seq_err}, 0);

        // out-of-order start, then correctly advancing pairs finish the row pass
        do_reset();
        clear_stats();
        step(1'b1, 10, 20, 0, 0, 2);
        for (int k = 2; k < PASS; k++) begin
            step(1'b1, int'($urandom_range(255)), int'($urandom_range(255)), 0, k / (W / 2), (k % (W / 2)) * 2);
        end
        idle(3);
        check("ooo_seq_err", {31'd0, o_seq_err}, 1);
        check("ooo_pd_count", pd_cnt, 1);
        idle(2);
        check("ooo_seq_err_sticky", {31'd0, o_seq_err}, 1);

        // reset in the middle of a pass
        do_reset();
        for (int k = 0; k < 3; k++) begin
            step(1'b1, int'($urandom_range(255)), int'($urandom_range(255)), 0, k / (W / 2), (k % (W / 2)) * 2);
        end
        do_reset();
        idle(3);
        step(1'b1, 33, 44, 0, 0, 0);
        idle(3);
        check("post_reset_no_err", {31'd0, o_seq_err}, 0);

        // random traffic with occasional bad tags and bubbles
        for (int k = 0; k < 80; k++) begin
            if ($urandom_range(3) == 0) begin
                m  = int'($urandom_range(1));
                rc = int'($urandom_range(3));
                px = int'($urandom_range(1)) * 2;
            end else begin
                m  = m_idx / PASS;
                rc = (m_idx % PASS) / (W / 2);
                px = (m_idx % (W / 2)) * 2;
            end
            step(($urandom_range(4) != 0), int'($urandom_range(255)), int'($urandom_range(255)), m, rc, px);
        end
        idle(3);
        check("rand_seq_err", {31'd0, o_seq_err}, {31'd0, m_err});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
